// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder_pkg : shared widths, FSM encoding, address check helper    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package dmem_responder_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_t;

  // Flags a misaligned address or any set bit above the stored word range.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int depth_log2);
    logic err;
    err = (addr[2:0] != 3'b000);
    for (int i = 0; i < ADDR_W; i++) begin
      if ((i >= depth_log2 + 3) && addr[i]) err = 1'b1;
    end
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_array : single-port 64-bit storage, sync write, async read, no reset |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge CLK) begin
    if (we) r_mem[idx] <= wdata;
  end

  assign rdata = r_mem[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder : valid/ready data-memory responder with wait states       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] c_cnt_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  dmr_state_t        r_state;
  dmr_state_t        w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic                  w_access;
  logic                  w_acc_write;
  logic [ADDR_W-1:0]     w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_we;
  logic [DATA_W-1:0]     w_mem_rdata;

  always_comb begin
    w_next   = r_state;
    w_access = 1'b0;
    case (r_state)
      DMR_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_access = 1'b1;
            w_next   = DMR_RESP;
          end else begin
            w_next = DMR_WAIT;
          end
        end
      end
      DMR_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = DMR_RESP;
        end
      end
      DMR_RESP: begin
        if (rsp_ready) w_next = DMR_IDLE;
      end
      default: w_next = DMR_IDLE;
    endcase
  end

  // A zero-latency access happens on the accept edge, so it must see the live request.
  always_comb begin
    w_acc_write = r_write;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    if (r_state == DMR_IDLE) begin
      w_acc_write = req_write;
      w_acc_addr  = req_addr;
      w_acc_wdata = req_wdata;
    end
  end

  assign w_err = addr_err(w_acc_addr, DEPTH_LOG2);
  assign w_idx = w_acc_addr[DEPTH_LOG2+2:3];
  assign w_we  = w_access & w_acc_write & ~w_err;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .CLK   (CLK),
    .we    (w_we),
    .idx   (w_idx),
    .wdata (w_acc_wdata),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) r_state <= DMR_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == DMR_IDLE && req_valid) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_cnt_init;
      end else if (r_state == DMR_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= (w_acc_write || w_err) ? '0 : w_mem_rdata;
        r_err   <= w_err;
      end
    end
  end

  assign req_ready = (r_state == DMR_IDLE);
  assign rsp_valid = (r_state == DMR_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder : directed bench, LATENCY=2 (a_) and LATENCY=0 (b_)      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

  logic        CLK;
  logic        resetl;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_a (
    .CLK(CLK), .resetl(resetl),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut_b (
    .CLK(CLK), .resetl(resetl),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Issues one request to DUT A and returns at the negedge where rsp_valid is seen;
  // lat is the number of posedges after the accept edge (-1 on timeout).
  task automatic a_issue(input logic w, input logic [63:0] addr, input logic [63:0] wd,
                         output int lat);
    @(negedge CLK);
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr; a_req_wdata = wd;
    a_rsp_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!a_rsp_valid) lat = -1;
  endtask

  task automatic a_complete();
    a_rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 64'h0 || a_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0/0", a_rsp_rdata, a_rsp_err); end
    checks++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_b got=%b/%b exp=1/0", b_req_ready, b_rsp_valid); end
    a_issue(1'b0, 64'h13, 64'h0, lat);
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b1) begin errors++; $display("FAIL pre_reset_resp got=%b/%b exp=1/1", a_rsp_valid, a_rsp_err); end
    #2 resetl = 1'b0;
    #1;
    checks++; if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 64'h0) begin
      errors++; $display("FAIL async_reset got=%b/%b/%h exp=0/0/0", a_rsp_valid, a_rsp_err, a_rsp_rdata);
    end
    #1 resetl = 1'b1;
    @(negedge CLK);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b exp=1", a_req_ready); end
  endtask

  task automatic test_store_load();
    int lat;
    a_issue(1'b1, 64'h10, 64'hDEADBEEF_01234567, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got=%0d exp=2", lat); end
    checks++; if (a_rsp_rdata !== 64'h0 || a_rsp_err !== 1'b0) begin errors++; $display("FAIL store_rsp got=%h/%b exp=0/0", a_rsp_rdata, a_rsp_err); end
    a_complete();
    a_issue(1'b0, 64'h10, 64'h0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got=%0d exp=2", lat); end
    checks++; if (a_rsp_rdata !== 64'hDEADBEEF_01234567 || a_rsp_err !== 1'b0) begin
      errors++; $display("FAIL load_data got=%h/%b exp=deadbeef01234567/0", a_rsp_rdata, a_rsp_err);
    end
    a_complete();
  endtask

  task automatic test_backpressure();
    int lat;
    a_issue(1'b0, 64'h10, 64'h0, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'hDEADBEEF_01234567) begin
        errors++; $display("FAIL hold_cycle%0d got=%b/%h exp=1/deadbeef01234567", i, a_rsp_valid, a_rsp_rdata);
      end
    end
    a_rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    a_rsp_ready = 1'b0;
    checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL release_idle got=%b/%b exp=0/1", a_rsp_valid, a_req_ready);
    end
  endtask

  task automatic test_errors();
    int lat;
    a_issue(1'b0, 64'h13, 64'h0, lat);
    checks++; if (lat !== 2 || a_rsp_err !== 1'b1 || a_rsp_rdata !== 64'h0) begin
      errors++; $display("FAIL misaligned got=%0d/%b/%h exp=2/1/0", lat, a_rsp_err, a_rsp_rdata);
    end
    a_complete();
    a_issue(1'b0, 64'h2000, 64'h0, lat);
    checks++; if (lat !== 2 || a_rsp_err !== 1'b1 || a_rsp_rdata !== 64'h0) begin
      errors++; $display("FAIL out_of_range got=%0d/%b/%h exp=2/1/0", lat, a_rsp_err, a_rsp_rdata);
    end
    a_complete();
    a_issue(1'b1, 64'h0, 64'h0000_0000_0000_CAFE, lat);
    a_complete();
    a_issue(1'b1, 64'h2000, 64'h1111_2222_3333_4444, lat);
    checks++; if (a_rsp_err !== 1'b1) begin errors++; $display("FAIL store_oor_err got=%b exp=1", a_rsp_err); end
    a_complete();
    a_issue(1'b0, 64'h0, 64'h0, lat);
    checks++; if (a_rsp_rdata !== 64'hCAFE || a_rsp_err !== 1'b0) begin
      errors++; $display("FAIL alias_unchanged got=%h/%b exp=cafe/0", a_rsp_rdata, a_rsp_err);
    end
    a_complete();
  endtask

  task automatic test_reset_abort();
    int lat;
    a_issue(1'b1, 64'h18, 64'hAA, lat);
    a_complete();
    @(negedge CLK);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 64'h18; a_req_wdata = 64'h55;
    @(posedge CLK);
    @(negedge CLK);
    a_req_valid = 1'b0;
    #1 resetl = 1'b0;
    #1 resetl = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_no_resp got=%b/%b exp=0/1", a_rsp_valid, a_req_ready);
    end
    a_issue(1'b0, 64'h18, 64'h0, lat);
    checks++; if (a_rsp_rdata !== 64'hAA) begin errors++; $display("FAIL abort_mem got=%h exp=aa", a_rsp_rdata); end
    a_complete();
  endtask

  task automatic test_latency0();
    int seen;
    @(negedge CLK);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 64'h8; b_req_wdata = 64'h1234;
    @(posedge CLK);
    @(negedge CLK);
    b_req_valid = 1'b0;
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0 || b_rsp_rdata !== 64'h0) begin
      errors++; $display("FAIL lat0_resp got=%b/%b/%h exp=1/0/0", b_rsp_valid, b_rsp_err, b_rsp_rdata);
    end
    b_rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL lat0_idle got=%b exp=1", b_req_ready); end
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 64'h8;
    seen = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      checks++; if (b_rsp_valid !== ((i % 2) == 1)) begin
        errors++; $display("FAIL b2b_valid cycle%0d got=%b exp=%b", i, b_rsp_valid, ((i % 2) == 1));
      end
      if (b_rsp_valid === 1'b1) begin
        seen++;
        checks++; if (b_rsp_rdata !== 64'h1234) begin errors++; $display("FAIL b2b_data got=%h exp=1234", b_rsp_rdata); end
      end
    end
    b_req_valid = 1'b0;
    b_rsp_ready = 1'b0;
    checks++; if (seen !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", seen); end
  endtask

  initial begin
    resetl = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
    repeat (3) @(negedge CLK);
    resetl = 1'b1;
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_reset_abort();
    test_latency0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
